// File: rtl/aes_pkg.sv
// Shared AES constants, state typedef and the GF(2^8) xtime helper used by
// the key schedule and MixColumns.
package aes_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  RCON_POLY  = 8'h1b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ke_state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Round-key stream between the key-expansion engine (slave) and its
// controller/consumer (master).
interface aes_key_expand_seq_if;
  import aes_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic             busy;
  logic             rk_valid;
  logic             rk_ready;
  logic [KEY_W-1:0] rk_out;
  logic [3:0]       rk_round;
  logic             done;

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_round, done
  );

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup, shared by SubWord and SubBytes.
module aes_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  // Row r holds S(16r) .. S(16r+15), first entry in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;

  assign w_base = 11'd2047 - {i_data, 3'b000};
  assign o_data = SBOX_TABLE[w_base -: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key expansion: emits round keys 0..10 one per
// handshake from a single key register, deriving each key on the fly.
module aes_key_expand_seq
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  aes_key_expand_seq_if.slave   bus
);

  ke_state_e        r_state;
  logic [KEY_W-1:0] r_key;
  logic [3:0]       r_round;
  logic [7:0]       r_rcon;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [31:0]      w_w0, w_w1, w_w2, w_w3;
  logic [31:0]      w_rot, w_sub, w_t;
  logic [31:0]      w_n0, w_n1, w_n2, w_n3;
  logic [KEY_W-1:0] w_next_key;
  logic             w_hs;

  assign w_w0  = r_key[127:96];
  assign w_w1  = r_key[95:64];
  assign w_w2  = r_key[63:32];
  assign w_w3  = r_key[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_data (w_rot[8*g +: 8]),
      .o_data (w_sub[8*g +: 8])
    );
  end

  assign w_t        = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};
  assign w_hs       = r_valid & bus.rk_ready;

  // Control FSM; the key register doubles as the registered rk_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_round <= 4'd0;
      r_rcon  <= RCON_INIT;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_key   <= bus.key_in;
            r_round <= 4'd0;
            r_rcon  <= RCON_INIT;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_EMIT;
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (w_hs) begin
            if (r_round == 4'(NUM_ROUNDS)) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_key   <= w_next_key;
              r_round <= r_round + 4'd1;
              r_rcon  <= xtime(r_rcon);
            end
          end else begin
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rk_out   = r_key;
  assign bus.rk_round = r_round;
  assign bus.rk_valid = r_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed self-checking bench for aes_key_expand_seq using FIPS-197 and
// all-zero key schedules.
module tb_aes_key_expand_seq;

  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO  = 128'h00000000000000000000000000000000;
  localparam logic [127:0] KEY_OTHER = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [127:0] obs_keys [0:10];
  logic [127:0] exp_fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 clk = ~clk;

  aes_key_expand_seq_if bus ();

  aes_key_expand_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: foreign start mid-run; 3: start held.
  task automatic run_keys(input logic [127:0] key, input int mode, input int abort_round,
                          output int n_acc, output int first_valid, output int done_cyc);
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    logic         prev_stall;
    n_acc       = 0;
    first_valid = -1;
    done_cyc    = -1;
    prev_stall  = 1'b0;
    prev_out    = '0;
    prev_round  = 4'd0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.key_in   = key;
    bus.rk_ready = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      bus.start = (mode == 3) || (mode == 2 && cyc == 3);
      if (mode == 2 && cyc == 3) bus.key_in = KEY_OTHER;
      else if (mode != 3) bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        check_val("hold_out", bus.rk_out, prev_out);
        check_val("hold_round", 128'(bus.rk_round), 128'(prev_round));
      end
      if (bus.done) begin
        done_cyc = cyc;
        check_val("done_valid_low", 128'(bus.rk_valid), 128'(0));
        check_val("done_busy_low", 128'(bus.busy), 128'(0));
        break;
      end
      if (bus.rk_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          check_val("busy_first", 128'(bus.busy), 128'(1));
        end
        if (abort_round >= 0 && int'(bus.rk_round) == abort_round) begin
          rst = 1'b1;
          break;
        end
        if (bus.rk_ready) begin
          check_val("round_order", 128'(bus.rk_round), 128'(n_acc));
          if (n_acc < 11) obs_keys[n_acc] = bus.rk_out;
          n_acc++;
        end
      end
      prev_stall = bus.rk_valid && !bus.rk_ready;
      prev_out   = bus.rk_out;
      prev_round = bus.rk_round;
    end
    if (done_cyc < 0 && abort_round < 0) check_val("done_timeout", 128'(0), 128'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, 128'(bus.rk_valid), 128'(0));
    check_val({tag, "_busy"}, 128'(bus.busy), 128'(0));
    check_val({tag, "_done"}, 128'(bus.done), 128'(0));
    check_val({tag, "_out"}, bus.rk_out, 128'h0);
    check_val({tag, "_round"}, 128'(bus.rk_round), 128'(0));
  endtask

  initial begin
    int n_acc, first_valid, done_cyc;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // FIPS-197 key, ready tied high.
    run_keys(KEY_FIPS, 0, -1, n_acc, first_valid, done_cyc);
    check_val("fips_count", 128'(n_acc), 128'(11));
    for (int i = 0; i < 11; i++) check_val($sformatf("fips_rk%0d", i), obs_keys[i], exp_fips[i]);
    check_val("done_latency", 128'(done_cyc - first_valid), 128'(11));
    check_val("first_valid_lat", 128'(first_valid), 128'(1));

    // Random backpressure.
    run_keys(KEY_FIPS, 1, -1, n_acc, first_valid, done_cyc);
    check_val("bp_count", 128'(n_acc), 128'(11));
    for (int i = 0; i < 11; i++) check_val($sformatf("bp_rk%0d", i), obs_keys[i], exp_fips[i]);

    // All-zero key.
    run_keys(KEY_ZERO, 0, -1, n_acc, first_valid, done_cyc);
    check_val("zero_rk0", obs_keys[0], KEY_ZERO);
    check_val("zero_rk1", obs_keys[1], 128'h62636363626363636263636362636363);
    check_val("zero_rk10", obs_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Foreign start during EMIT must be ignored.
    run_keys(KEY_FIPS, 2, -1, n_acc, first_valid, done_cyc);
    check_val("inj_count", 128'(n_acc), 128'(11));
    for (int i = 0; i < 11; i++) check_val($sformatf("inj_rk%0d", i), obs_keys[i], exp_fips[i]);

    // Reset at round 5, then a fresh run from round 0.
    run_keys(KEY_FIPS, 0, 5, n_acc, first_valid, done_cyc);
    check_val("abort_acc", 128'(n_acc), 128'(5));
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    run_keys(KEY_ZERO, 0, -1, n_acc, first_valid, done_cyc);
    check_val("rerun_count", 128'(n_acc), 128'(11));
    check_val("rerun_rk0", obs_keys[0], KEY_ZERO);
    check_val("rerun_rk10", obs_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Start held through done: back-to-back run begins immediately.
    run_keys(KEY_FIPS, 3, -1, n_acc, first_valid, done_cyc);
    check_val("hold_count", 128'(n_acc), 128'(11));
    check_val("hold_rk10", obs_keys[10], exp_fips[10]);
    @(negedge clk);
    bus.start = 1'b0;
    check_val("b2b_valid", 128'(bus.rk_valid), 128'(1));
    check_val("b2b_round", 128'(bus.rk_round), 128'(0));
    check_val("b2b_key", bus.rk_out, KEY_FIPS);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
